data_ram: RTL
=============

# data_ram

Word-organised data memory: the responder at the far end of the memory stage's RAM port. It accepts one load or store per request, adds a configurable wait-state latency, and acknowledges with read data or a write-commit. The memory stage does byte/halfword lane handling and read-modify-write merging upstream, so this block only ever stores and returns full 32-bit words. It sits between the memory stage and the pipeline stall logic; `busy_o` and `ack_o` feed the hazard unit.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width from the memory stage.
- `DATA_WIDTH`, 32, word width.
- `DEPTH`, 4096, number of words; power of two, minimum 4.
- `WAIT_CYCLES`, 2, extra wait states per access; 0–15.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  input  1  clock; all state changes on its rising edge.
- `rst_ni`  input  1  asynchronous active-low reset.
- `req_i`  input  1  access request from the memory stage.
- `we_i`  input  1  1 = store, 0 = load; sampled with `req_i`.
- `addr_i`  input  `ADDR_WIDTH`  byte address; `addr_i[1:0]` ignored.
- `wdata_i`  input  `DATA_WIDTH`  merged store word.
- `rdata_o`  output  `DATA_WIDTH`  load data; valid while `ack_o` is high for a load.
- `ack_o`  output  1  one-cycle completion pulse.
- `err_o`  output  1  out-of-range access; high only together with `ack_o`.
- `busy_o`  output  1  high when state is not IDLE.

## Operation
- States are IDLE, WAIT and ACK.
- **IDLE:**
  - If `req_i` is high at a clock edge, latch `we_i`, `addr_i` and `wdata_i`, and load the counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES` > 0, otherwise go to ACK.
  - If `req_i` is low, stay in IDLE.
- **WAIT:** decrement the counter every edge. On the edge where the counter equals 1, go to ACK.
- **Entering ACK** (on that edge):
  - Compute the word index as latched `addr[log2(DEPTH)+1:2]`.
  - The access is in range when latched `addr >> 2` < `DEPTH`.
  - In-range store: commit `wdata` to the array.
  - In-range load: register the array word into `rdata_o`.
  - Out-of-range access: drop any write, force `rdata_o` to 0, set `err_o`.
- **ACK:** `ack_o` is high for exactly one cycle, then the block returns unconditionally to IDLE.
- A new request can be sampled on the first IDLE edge after ACK.
- `req_i` and the address/data inputs are ignored outside IDLE. Dropping or changing them mid-transaction has no effect; the latched values complete.
- On a store, `rdata_o` holds its previous value.
- Between acks, `rdata_o` holds the last load value.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, counter 0, `ack_o` 0, `err_o` 0, `busy_o` 0, `rdata_o` 0.
- Reset asserted mid-transaction aborts it. A store not yet at the ACK-entry edge is never written.
- Latency: with the request sampled at edge E, `ack_o` is high in the cycle after edge E+`WAIT_CYCLES`. That gives `WAIT_CYCLES`+1 cycles.
- Throughput: one access per `WAIT_CYCLES`+2 cycles when requests are back-to-back.
- `busy_o` rises in the cycle after the sampling edge and falls in the cycle after ACK.
- Read-after-write to the same word returns the new data, because writes commit before the next request is sampled.

## Configuration
- **`DATA_RAM_WAIT_EN` defined:** the WAIT state and counter are compiled in and `WAIT_CYCLES` is honoured.
- **`DATA_RAM_WAIT_EN` not defined:**
  - The WAIT state and counter are removed and `WAIT_CYCLES` is ignored.
  - IDLE always goes directly to ACK.
  - Fixed latency is 1 cycle and throughput is one access per 2 cycles.

## Test plan
- **Reset:** assert `rst_ni`=0 asynchronously mid-cycle -> all outputs 0 immediately; state IDLE after release.
- **Store then load** (macro on, `WAIT_CYCLES`=2):
  - Store 0xDEADBEEF to 0x0000_0010 -> `ack_o` high 3 cycles after sampling, `busy_o` high for 3 cycles.
  - Load 0x0000_0013 -> `rdata_o`=0xDEADBEEF with `ack_o`.
- **Out-of-range** (`DEPTH`=4096):
  - Store 0x5555_5555 to 0x0000_4000 -> `err_o`=1 with `ack_o`.
  - Load 0x0000_0000 -> returns the prior contents, unchanged.
  - Load 0x0000_4000 -> `rdata_o`=0, `err_o`=1.
- **Request withdrawn:** drop `req_i` and change `addr_i` during WAIT -> the original latched store still commits and `ack_o` pulses once.
- **Reset mid-WAIT:** store 0x1234_5678 to 0x20, assert reset during WAIT -> a later load of 0x20 returns the old value, not 0x1234_5678.
- **Macro off:**
  - Back-to-back loads -> `ack_o` on every second cycle, one cycle after each sampling edge.
  - `WAIT_CYCLES`=7 has no effect.

Source files
------------

// File: rtl/data_ram.sv
// Word-organised data memory responding to the memory stage with a wait-state latency.
// Define DATA_RAM_WAIT_EN to compile in the WAIT state and honour WAIT_CYCLES.
module data_ram #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_WIDTH - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic                  we_q;
  logic [WA_W-1:0]       waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  sampling;
  logic                  enter_ack;
  logic                  acc_we;
  logic [WA_W-1:0]       acc_waddr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  unused_lsbs;

  assign unused_lsbs = ^addr_i[1:0];

`ifdef DATA_RAM_WAIT_EN
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q;
`else
  localparam int UNUSED_WAIT = WAIT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    enter_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
`ifdef DATA_RAM_WAIT_EN
          if (WAIT_INIT != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d   = S_ACK;
            enter_ack = 1'b1;
          end
`else
          state_d   = S_ACK;
          enter_ack = 1'b1;
`endif
        end
      end
`ifdef DATA_RAM_WAIT_EN
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d   = S_ACK;
          enter_ack = 1'b1;
        end
      end
`endif
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access completes on the sampling edge, so it
  // must use the live inputs rather than the not-yet-latched copies.
  assign sampling  = (state_q == S_IDLE);
  assign acc_we    = sampling ? we_i : we_q;
  assign acc_waddr = sampling ? addr_i[ADDR_WIDTH-1:2] : waddr_q;
  assign acc_wdata = sampling ? wdata_i : wdata_q;
  assign in_range  = (acc_waddr < WA_W'(DEPTH));
  assign idx       = acc_waddr[IDX_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef DATA_RAM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      if (sampling && req_i) begin
        we_q    <= we_i;
        waddr_q <= addr_i[ADDR_WIDTH-1:2];
        wdata_q <= wdata_i;
`ifdef DATA_RAM_WAIT_EN
        cnt_q   <= WAIT_INIT;
`endif
      end
`ifdef DATA_RAM_WAIT_EN
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
`endif
      if (enter_ack) begin
        err_q <= !in_range;
        if (!in_range) begin
          rdata_q <= '0;
        end else if (!acc_we) begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

  // Contents are not reset; rst_ni gating keeps a held request from writing during reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enter_ack && acc_we && in_range) begin
      mem[idx] <= acc_wdata;
    end
  end

  assign ack_o   = (state_q == S_ACK);
  assign err_o   = ack_o & err_q;
  assign busy_o  = (state_q != S_IDLE);
  assign rdata_o = rdata_q;
  assign state_o = state_q;

endmodule
